// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship game core: FSM state encoding
// and the 8-bit LFSR seed/taps used for CPU ship placement and targeting.
package battleship_pkg;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_SET_AMOUNT   = 3'd1,
        S_PLACE_PLAYER = 3'd2,
        S_PLACE_CPU    = 3'd3,
        S_PLAYER_TURN  = 3'd4,
        S_CPU_TURN     = 3'd5,
        S_WIN          = 3'd6,
        S_LOSE         = 3'd7
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps at bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        logic fb;
        fb = ^(q & LFSR_TAPS);
        return {q[6:0], fb};
    endfunction

endpackage

// File: rtl/battleship_lfsr.sv
// Free-running 8-bit maximal-length LFSR, the game's only source of randomness.
module battleship_lfsr
    import battleship_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    // The zero check only recovers from an upset; a maximal sequence never reaches 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= LFSR_SEED;
        end else if (value == 8'h00) begin
            value <= LFSR_SEED;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/battleship_core.sv
// Battleship game controller: button edge detection, cursor, ship placement,
// alternating player/CPU turns and win/lose detection on an N x N board.
module battleship_core
    import battleship_pkg::*;
#(
    parameter int  GRID_N    = 5,
    parameter int  MAX_SHIPS = 5,
    parameter int  WRAP      = 1,
    parameter int  CPU_DELAY = 4,
    localparam int AW        = $clog2(MAX_SHIPS + 1),
    localparam int CW        = $clog2(GRID_N),
    localparam int NCELL     = GRID_N * GRID_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             move_up,
    input  logic             move_down,
    input  logic             move_left,
    input  logic             move_right,
    input  logic             player_move,
    input  logic [AW-1:0]    player_ships_input,
    input  logic             confirm_amount_button,
    output logic [AW-1:0]    game_ships_amount,
    output logic [CW-1:0]    cursor_x,
    output logic [CW-1:0]    cursor_y,
    output logic [NCELL-1:0] player_ship_map,
    output logic [NCELL-1:0] player_hit_map,
    output logic [NCELL-1:0] cpu_shot_map,
    output logic [NCELL-1:0] cpu_hit_map,
    output logic [2:0]       game_state,
    output logic [AW-1:0]    ships_placed
);

    localparam int            IW      = $clog2(NCELL);
    localparam logic [AW-1:0] MAX_AMT = AW'(MAX_SHIPS);
    localparam logic [7:0]    DELAY_C = 8'(CPU_DELAY);

    logic [6:0] btn, btn_prev, btn_edge;
    logic       start_e, up_e, down_e, left_e, right_e, move_e, confirm_e;

    state_t           state, state_n;
    logic [AW-1:0]    amount_n, placed_n, cpu_placed, cpu_placed_n;
    logic [CW-1:0]    cx_n, cy_n;
    logic [7:0]       delay_cnt, delay_n;
    logic [NCELL-1:0] pship_n, phit_n, cship, cship_n, cshot_n, chit_n;
    logic             clear;

    logic [7:0]    lfsr_value;
    logic [IW-1:0] cur_idx, rnd_idx;

    battleship_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_value)
    );

    assign btn = {start, move_up, move_down, move_left, move_right,
                  player_move, confirm_amount_button};
    assign btn_edge = btn & ~btn_prev;
    assign {start_e, up_e, down_e, left_e, right_e, move_e, confirm_e} = btn_edge;

    assign cur_idx    = IW'(cursor_y) * IW'(GRID_N) + IW'(cursor_x);
    assign rnd_idx    = IW'({24'd0, lfsr_value} % NCELL);
    assign game_state = state;

    function automatic logic [CW-1:0] step_dec(input logic [CW-1:0] c);
        if (c != '0) return c - CW'(1);
        return (WRAP != 0) ? CW'(GRID_N - 1) : c;
    endfunction

    function automatic logic [CW-1:0] step_inc(input logic [CW-1:0] c);
        if (c != CW'(GRID_N - 1)) return c + CW'(1);
        return (WRAP != 0) ? '0 : c;
    endfunction

    always_comb begin
        state_n      = state;
        amount_n     = game_ships_amount;
        placed_n     = ships_placed;
        cpu_placed_n = cpu_placed;
        cx_n         = cursor_x;
        cy_n         = cursor_y;
        delay_n      = delay_cnt;
        pship_n      = player_ship_map;
        phit_n       = player_hit_map;
        cship_n      = cship;
        cshot_n      = cpu_shot_map;
        chit_n       = cpu_hit_map;
        clear        = 1'b0;

        // One cursor step per cycle; the lower-priority edges are dropped.
        if (state == S_PLACE_PLAYER || state == S_PLAYER_TURN) begin
            if (up_e)         cy_n = step_dec(cursor_y);
            else if (down_e)  cy_n = step_inc(cursor_y);
            else if (left_e)  cx_n = step_dec(cursor_x);
            else if (right_e) cx_n = step_inc(cursor_x);
        end

        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start_e) begin
                    state_n = S_SET_AMOUNT;
                    clear   = 1'b1;
                end
            end
            S_SET_AMOUNT: begin
                if (confirm_e && player_ships_input != '0) begin
                    amount_n = (player_ships_input > MAX_AMT) ? MAX_AMT : player_ships_input;
                    placed_n = '0;
                    state_n  = S_PLACE_PLAYER;
                end
            end
            S_PLACE_PLAYER: begin
                if (move_e && !player_ship_map[cur_idx]) begin
                    pship_n[cur_idx] = 1'b1;
                    placed_n         = ships_placed + AW'(1);
                    if (placed_n == game_ships_amount) begin
                        cpu_placed_n = '0;
                        state_n      = S_PLACE_CPU;
                    end
                end
            end
            S_PLACE_CPU: begin
                if (!cship[rnd_idx]) begin
                    cship_n[rnd_idx] = 1'b1;
                    cpu_placed_n     = cpu_placed + AW'(1);
                    if (cpu_placed_n == game_ships_amount) state_n = S_PLAYER_TURN;
                end
            end
            S_PLAYER_TURN: begin
                if (move_e && !cpu_shot_map[cur_idx]) begin
                    cshot_n[cur_idx] = 1'b1;
                    if (cship[cur_idx]) chit_n[cur_idx] = 1'b1;
                    if (cship[cur_idx] && ((cship & ~chit_n) == '0)) begin
                        state_n = S_WIN;
                    end else begin
                        delay_n = '0;
                        state_n = S_CPU_TURN;
                    end
                end
            end
            S_CPU_TURN: begin
                if (delay_cnt < DELAY_C) begin
                    delay_n = delay_cnt + 8'd1;
                end else if (!player_hit_map[rnd_idx]) begin
                    phit_n[rnd_idx] = 1'b1;
                    state_n = ((player_ship_map & ~phit_n) == '0) ? S_LOSE : S_PLAYER_TURN;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (clear) begin
            amount_n     = '0;
            placed_n     = '0;
            cpu_placed_n = '0;
            cx_n         = '0;
            cy_n         = '0;
            delay_n      = '0;
            pship_n      = '0;
            phit_n       = '0;
            cship_n      = '0;
            cshot_n      = '0;
            chit_n       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev          <= '0;
            state             <= S_IDLE;
            game_ships_amount <= '0;
            ships_placed      <= '0;
            cpu_placed        <= '0;
            cursor_x          <= '0;
            cursor_y          <= '0;
            delay_cnt         <= '0;
            player_ship_map   <= '0;
            player_hit_map    <= '0;
            cship             <= '0;
            cpu_shot_map      <= '0;
            cpu_hit_map       <= '0;
        end else begin
            btn_prev          <= btn;
            state             <= state_n;
            game_ships_amount <= amount_n;
            ships_placed      <= placed_n;
            cpu_placed        <= cpu_placed_n;
            cursor_x          <= cx_n;
            cursor_y          <= cy_n;
            delay_cnt         <= delay_n;
            player_ship_map   <= pship_n;
            player_hit_map    <= phit_n;
            cship             <= cship_n;
            cpu_shot_map      <= cshot_n;
            cpu_hit_map       <= chit_n;
        end
    end

endmodule

// File: tb/tb_battleship_core.sv
// Self-checking bench for battleship_core: wrapping and saturating cursor
// instances, an independent LFSR/CPU model, and an expected-value queue.
module tb_battleship_core;
    import battleship_pkg::*;

    localparam int GRID_N    = 5;
    localparam int MAX_SHIPS = 5;
    localparam int CPU_DELAY = 4;
    localparam int AW        = 3;
    localparam int CW        = 3;
    localparam int NC        = GRID_N * GRID_N;

    localparam int O_STATE = 0, O_AMT = 1, O_PLACED = 2, O_CX = 3, O_CY = 4, O_PSHIP = 5;
    localparam int O_PHIT = 6, O_CSHOT = 7, O_CHIT = 8, O_SCX = 9, O_SCY = 10, O_LFSR = 11;
    localparam int B_START = 0, B_UP = 1, B_DOWN = 2, B_LEFT = 3, B_RIGHT = 4, B_MOVE = 5, B_CONFIRM = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, move_up = 1'b0, move_down = 1'b0, move_left = 1'b0;
    logic          move_right = 1'b0, player_move = 1'b0, confirm = 1'b0;
    logic [AW-1:0] ships_in = '0;

    logic [AW-1:0] amount, placed, s_amount, s_placed;
    logic [CW-1:0] cx, cy, s_cx, s_cy;
    logic [NC-1:0] pship, phit, cshot, chit, s_pship, s_phit, s_cshot, s_chit;
    logic [2:0]    gstate, s_gstate;

    int n_checks = 0;
    int n_errors = 0;
    int cur_x = 0;
    int cur_y = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    battleship_core #(.GRID_N(GRID_N), .MAX_SHIPS(MAX_SHIPS), .WRAP(1), .CPU_DELAY(CPU_DELAY)) dut (
        .clk(clk), .rst(rst), .start(start), .move_up(move_up), .move_down(move_down),
        .move_left(move_left), .move_right(move_right), .player_move(player_move),
        .player_ships_input(ships_in), .confirm_amount_button(confirm),
        .game_ships_amount(amount), .cursor_x(cx), .cursor_y(cy),
        .player_ship_map(pship), .player_hit_map(phit), .cpu_shot_map(cshot),
        .cpu_hit_map(chit), .game_state(gstate), .ships_placed(placed)
    );

    battleship_core #(.GRID_N(GRID_N), .MAX_SHIPS(MAX_SHIPS), .WRAP(0), .CPU_DELAY(CPU_DELAY)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .move_up(move_up), .move_down(move_down),
        .move_left(move_left), .move_right(move_right), .player_move(player_move),
        .player_ships_input(ships_in), .confirm_amount_button(confirm),
        .game_ships_amount(s_amount), .cursor_x(s_cx), .cursor_y(s_cy),
        .player_ship_map(s_pship), .player_hit_map(s_phit), .cpu_shot_map(s_cshot),
        .cpu_hit_map(s_chit), .game_state(s_gstate), .ships_placed(s_placed)
    );

    // ---------------- reference model: LFSR, hidden CPU ships, CPU shots ----------------
    logic [7:0]    lfsr_m;
    logic [NC-1:0] cship_m, phit_m;
    int            cpu_wait_m;

    function automatic logic [7:0] lfsr_step(input logic [7:0] m);
        return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_m     <= 8'hA5;
            cship_m    <= '0;
            phit_m     <= '0;
            cpu_wait_m <= 0;
        end else begin
            lfsr_m <= lfsr_step(lfsr_m);
            if (gstate == S_SET_AMOUNT) begin
                cship_m <= '0;
                phit_m  <= '0;
            end
            if (gstate == S_PLACE_CPU) cship_m[int'(lfsr_m) % NC] <= 1'b1;
            if (gstate == S_CPU_TURN) begin
                if (cpu_wait_m == CPU_DELAY) phit_m[int'(lfsr_m) % NC] <= 1'b1;
                else cpu_wait_m <= cpu_wait_m + 1;
            end else begin
                cpu_wait_m <= 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    string       tag_q[$];
    int          sel_q[$];
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            O_STATE:  return 32'(gstate);
            O_AMT:    return 32'(amount);
            O_PLACED: return 32'(placed);
            O_CX:     return 32'(cx);
            O_CY:     return 32'(cy);
            O_PSHIP:  return 32'(pship);
            O_PHIT:   return 32'(phit);
            O_CSHOT:  return 32'(cshot);
            O_CHIT:   return 32'(chit);
            O_SCX:    return 32'(s_cx);
            O_SCY:    return 32'(s_cy);
            O_LFSR:   return 32'(dut.u_lfsr.value);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] val);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(val);
    endtask

    task automatic drain();
        string       t;
        int          s;
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            check(t, observe(s), e);
        end
    endtask

    task automatic expect_clear(input string pfx);
        expect_out({pfx, "_amount"}, O_AMT, 0);
        expect_out({pfx, "_placed"}, O_PLACED, 0);
        expect_out({pfx, "_cx"}, O_CX, 0);
        expect_out({pfx, "_cy"}, O_CY, 0);
        expect_out({pfx, "_pship"}, O_PSHIP, 0);
        expect_out({pfx, "_phit"}, O_PHIT, 0);
        expect_out({pfx, "_cshot"}, O_CSHOT, 0);
        expect_out({pfx, "_chit"}, O_CHIT, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_btn(input int b, input logic v);
        case (b)
            B_START:   start       = v;
            B_UP:      move_up     = v;
            B_DOWN:    move_down   = v;
            B_LEFT:    move_left   = v;
            B_RIGHT:   move_right  = v;
            B_MOVE:    player_move = v;
            B_CONFIRM: confirm     = v;
            default:   ;
        endcase
    endtask

    task automatic press(input int b);
        @(negedge clk);
        set_btn(b, 1'b1);
        @(negedge clk);
        set_btn(b, 1'b0);
    endtask

    task automatic goto(input int x, input int y);
        while (cur_x != x) begin
            press(B_RIGHT);
            cur_x = (cur_x + 1) % GRID_N;
        end
        while (cur_y != y) begin
            press(B_DOWN);
            cur_y = (cur_y + 1) % GRID_N;
        end
        expect_out("goto_cx", O_CX, x);
        expect_out("goto_cy", O_CY, y);
        drain();
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget, output int cycles);
        cycles = 0;
        while (gstate != s && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, 32'(gstate), 32'(s));
    endtask

    function automatic int first_free(input int skip);
        for (int i = 0; i < NC; i++) if (!cship_m[i] && i != skip) return i;
        return 0;
    endfunction

    function automatic int first_ship();
        for (int i = 0; i < NC; i++) if (cship_m[i]) return i;
        return 0;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int ci, cj, ck;
        logic [NC-1:0] pship_e;

        repeat (3) @(negedge clk);
        expect_out("rst_state", O_STATE, S_IDLE);
        expect_clear("rst");
        expect_out("rst_lfsr", O_LFSR, 8'hA5);
        drain();
        rst = 1'b1;

        press(B_RIGHT);
        expect_out("idle_ignore_state", O_STATE, S_IDLE);
        expect_out("idle_ignore_cx", O_CX, 0);
        drain();

        press(B_START);
        expect_out("start_state", O_STATE, S_SET_AMOUNT);
        drain();

        ships_in = 3'd0;
        press(B_CONFIRM);
        expect_out("zero_amount_state", O_STATE, S_SET_AMOUNT);
        expect_out("zero_amount_amt", O_AMT, 0);
        drain();

        ships_in = 3'd7;
        press(B_CONFIRM);
        expect_out("clamp_amt", O_AMT, MAX_SHIPS);
        expect_out("clamp_state", O_STATE, S_PLACE_PLAYER);
        drain();

        press(B_UP);
        press(B_LEFT);
        expect_out("wrap_cx", O_CX, 4);
        expect_out("wrap_cy", O_CY, 4);
        expect_out("sat_cx", O_SCX, 0);
        expect_out("sat_cy", O_SCY, 0);
        drain();

        @(negedge clk);
        move_down = 1'b1;
        repeat (10) @(negedge clk);
        move_down = 1'b0;
        expect_out("held_wrap_cx", O_CX, 4);
        expect_out("held_wrap_cy", O_CY, 0);
        expect_out("held_sat_cx", O_SCX, 0);
        expect_out("held_sat_cy", O_SCY, 1);
        drain();

        @(negedge clk);
        move_up = 1'b1;
        move_right = 1'b1;
        @(negedge clk);
        move_up = 1'b0;
        move_right = 1'b0;
        expect_out("prio_wrap_cx", O_CX, 4);
        expect_out("prio_wrap_cy", O_CY, 4);
        expect_out("prio_sat_cx", O_SCX, 0);
        expect_out("prio_sat_cy", O_SCY, 0);
        drain();

        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out("midreset_state", O_STATE, S_IDLE);
        expect_clear("midreset");
        drain();
        @(negedge clk);
        rst = 1'b1;
        cur_x = 0;
        cur_y = 0;

        // Game with two ships: placement, CPU placement, turns, reset in CPU_TURN
        press(B_START);
        ships_in = 3'd2;
        press(B_CONFIRM);
        expect_out("g2_amt", O_AMT, 2);
        expect_out("g2_state", O_STATE, S_PLACE_PLAYER);
        drain();

        goto(1, 1);
        press(B_MOVE);
        expect_out("place1_placed", O_PLACED, 1);
        expect_out("place1_pship", O_PSHIP, 32'(1) << 6);
        drain();
        press(B_MOVE);
        expect_out("place_dup_placed", O_PLACED, 1);
        expect_out("place_dup_state", O_STATE, S_PLACE_PLAYER);
        drain();

        goto(2, 2);
        pship_e = '0;
        pship_e[6] = 1'b1;
        pship_e[12] = 1'b1;
        press(B_MOVE);
        expect_out("place2_placed", O_PLACED, 2);
        expect_out("place2_state", O_STATE, S_PLACE_CPU);
        expect_out("place2_pship", O_PSHIP, 32'(pship_e));
        drain();

        wait_state("g2_to_player_turn", S_PLAYER_TURN, 300, cyc);
        check("place_cpu_min_cycles", 32'(cyc >= 2), 1);

        ci = first_free(-1);
        goto(ci % GRID_N, ci / GRID_N);
        press(B_MOVE);
        expect_out("fire_miss_state", O_STATE, S_CPU_TURN);
        expect_out("fire_miss_cshot", O_CSHOT, 32'(1) << ci);
        expect_out("fire_miss_chit", O_CHIT, 0);
        drain();

        cyc = 0;
        while (gstate == S_CPU_TURN && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("cpu_delay_cycles", cyc, CPU_DELAY + 1);
        check("cpu_one_shot", $countones(phit), 1);
        expect_out("cpu_shot_map", O_PHIT, 32'(phit_m));
        expect_out("after_cpu_state", O_STATE,
                   ((pship_e & ~phit_m) == '0) ? S_LOSE : S_PLAYER_TURN);
        drain();

        press(B_MOVE);
        expect_out("refire_state", O_STATE, S_PLAYER_TURN);
        expect_out("refire_cshot", O_CSHOT, 32'(1) << ci);
        drain();
        repeat (3) @(negedge clk);
        expect_out("refire_hold_state", O_STATE, S_PLAYER_TURN);
        drain();

        cj = first_free(ci);
        goto(cj % GRID_N, cj / GRID_N);
        press(B_MOVE);
        expect_out("fire2_state", O_STATE, S_CPU_TURN);
        expect_out("fire2_cshot", O_CSHOT, (32'(1) << ci) | (32'(1) << cj));
        drain();

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out("cpu_turn_reset_state", O_STATE, S_IDLE);
        expect_clear("cpu_turn_reset");
        expect_out("cpu_turn_reset_lfsr", O_LFSR, 8'hA5);
        drain();
        @(negedge clk);
        rst = 1'b1;
        cur_x = 0;
        cur_y = 0;

        // Game with one ship: sink the modelled CPU ship for a win, then restart
        press(B_START);
        expect_out("g3_start_state", O_STATE, S_SET_AMOUNT);
        drain();
        ships_in = 3'd1;
        press(B_CONFIRM);
        press(B_MOVE);
        expect_out("g3_amt", O_AMT, 1);
        expect_out("g3_placed", O_PLACED, 1);
        expect_out("g3_state", O_STATE, S_PLACE_CPU);
        expect_out("g3_pship", O_PSHIP, 1);
        drain();

        wait_state("g3_to_player_turn", S_PLAYER_TURN, 300, cyc);
        ck = first_ship();
        goto(ck % GRID_N, ck / GRID_N);
        press(B_MOVE);
        expect_out("win_state", O_STATE, S_WIN);
        expect_out("win_chit", O_CHIT, 32'(1) << ck);
        expect_out("win_cshot", O_CSHOT, 32'(1) << ck);
        drain();

        @(negedge clk);
        start = 1'b1;
        move_right = 1'b1;
        @(negedge clk);
        start = 1'b0;
        move_right = 1'b0;
        expect_out("restart_state", O_STATE, S_SET_AMOUNT);
        expect_clear("restart");
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/battleship_core.md
BATTLESHIP_CORE -- requirements
Module: battleship_core

Interface
REQ-001 SHALL have parameter GRID_N, 5, board side length in cells (2..8).
REQ-002 SHALL have parameter MAX_SHIPS, 5, maximum ships per side (1..7); AW = $clog2(MAX_SHIPS+1), CW = $clog2(GRID_N).
REQ-003 SHALL have parameter WRAP, 1, cursor mode (1 = wrap at edges, 0 = saturate at edges).
REQ-004 SHALL have parameter CPU_DELAY, 4, idle cycles before the CPU fires (1..255).
REQ-005 clk  in  1  single clock; one clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  begin a new game (edge-detected).
REQ-008 move_up  in  1  cursor y-1 (edge-detected).
REQ-009 move_down  in  1  cursor y+1 (edge-detected).
REQ-010 move_left  in  1  cursor x-1 (edge-detected).
REQ-011 move_right  in  1  cursor x+1 (edge-detected).
REQ-012 player_move  in  1  place ship or fire at cursor (edge-detected).
REQ-013 player_ships_input  in  AW  requested ship count.
REQ-014 confirm_amount_button  in  1  latch player_ships_input (edge-detected).
REQ-015 game_ships_amount  out  AW  confirmed ship count per side.
REQ-016 cursor_x / cursor_y  out  CW each  cursor column / row, (0,0) top-left.
REQ-017 player_ship_map  out  GRID_N*GRID_N  player ships; bit index y*GRID_N+x.
REQ-018 player_hit_map  out  GRID_N*GRID_N  player cells shot by CPU.
REQ-019 cpu_shot_map / cpu_hit_map  out  GRID_N*GRID_N each  player shots on CPU board / those that hit.
REQ-020 game_state  out  3  current FSM state encoding.
REQ-021 ships_placed  out  AW  player ships placed so far.

Function
REQ-022 Every edge-detected input SHALL act once, on the cycle after its 0->1 transition; held-high inputs SHALL NOT repeat.
REQ-023 FSM states: IDLE, SET_AMOUNT, PLACE_PLAYER, PLACE_CPU, PLAYER_TURN, CPU_TURN, WIN, LOSE.
REQ-024 IDLE: start -> SET_AMOUNT; all other inputs ignored.
REQ-025 SET_AMOUNT: confirm with input 0 SHALL be ignored; input > MAX_SHIPS SHALL latch MAX_SHIPS; otherwise latch input; then -> PLACE_PLAYER.
REQ-026 Cursor moves SHALL apply in PLACE_PLAYER and PLAYER_TURN only; simultaneous move edges resolve by priority up > down > left > right, one move per cycle.
REQ-027 Edge move: WRAP=1 wraps 0 <-> GRID_N-1; WRAP=0 holds the coordinate.
REQ-028 PLACE_PLAYER: player_move on an empty cell sets the ship bit and increments ships_placed; on an occupied cell no effect; when ships_placed reaches game_ships_amount -> PLACE_CPU.
REQ-029 PLACE_CPU: each cycle, cell = lfsr mod GRID_N*GRID_N; if empty place a hidden CPU ship, else retry next cycle; after game_ships_amount placements -> PLAYER_TURN.
REQ-030 PLAYER_TURN: player_move on an unshot CPU cell sets cpu_shot_map, and also cpu_hit_map on a CPU ship; last CPU ship hit -> WIN, otherwise -> CPU_TURN; an already-shot cell is ignored and the state is held.
REQ-031 CPU_TURN: wait CPU_DELAY cycles, then each cycle pick lfsr mod GRID_N*GRID_N; an already-shot cell retries next cycle; otherwise set player_hit_map, and the last player ship hit -> LOSE, else -> PLAYER_TURN.
REQ-032 WIN/LOSE: hold all maps; start -> SET_AMOUNT with every map, count and cursor cleared.
REQ-033 The LFSR SHALL be 8-bit maximal-length (x^8+x^6+x^5+x^4+1), free-running every cycle, never all-zero.
REQ-034 All outputs SHALL be registered; simultaneous start with another input in IDLE, WIN or LOSE honours only start.

Reset
REQ-035 rst low SHALL immediately force IDLE, all maps 0, cursor (0,0), game_ships_amount 0, ships_placed 0, delay counter 0, LFSR 8'hA5, edge-detect history 0.
REQ-036 Reset mid-game SHALL discard the game entirely; after release the first start edge enters SET_AMOUNT.

Structure
REQ-037 Package battleship_pkg SHALL hold the state enum, LFSR seed and tap constants.
REQ-038 The LFSR SHALL be a separate sub-module battleship_lfsr; the edge detectors and FSM stay in battleship_core.

Verification
REQ-039 Reset, start, input 0 confirmed -> state stays SET_AMOUNT; input 7 confirmed -> game_ships_amount=5.
REQ-040 WRAP=1 at (0,0), move_up then move_left -> cursor (4,4); WRAP=0, same stimulus -> (0,0); move_up held 10 cycles -> one move only.
REQ-041 Amount 2; place at (1,1) twice -> ships_placed=1; place (2,2) -> ships_placed=2, PLACE_CPU, then PLAYER_TURN after 2 CPU placements.
REQ-042 PLAYER_TURN, fire the same cell twice -> second ignored, state PLAYER_TURN; CPU fires exactly CPU_DELAY+1 or more cycles after entering CPU_TURN.
REQ-043 Amount 1; bench reads the hidden CPU ship and fires it -> cpu_hit_map bit set, WIN; start -> SET_AMOUNT, all maps 0.
REQ-044 rst asserted in CPU_TURN -> same cycle IDLE, maps 0, LFSR 8'hA5.
